// File: rtl/imem_loader_pkg.sv
// ============================================================================
// imem_loader_pkg : shared state encoding and defaults for the imem loader
// Revision 1.0
// ============================================================================
`default_nettype none

package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_SYNC = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CSUM = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

   // States in which a frame is in progress and the idle timeout applies
   function automatic logic in_frame(input state_t s);
      return (s == ST_LEN) || (s == ST_DATA) || (s == ST_CSUM);
   endfunction

endpackage

`default_nettype wire

// File: rtl/imem_loader_idle_timer.sv
// ============================================================================
// imem_loader_idle_timer : clear/enable idle counter with terminal-count flag
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_loader_idle_timer #(
   parameter int unsigned TIMEOUT = 255,
   localparam int unsigned TW     = $clog2(TIMEOUT + 1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // Flags the idle cycle whose increment brings the count up to TIMEOUT
   assign tc = en && !clr && (count_q == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// imem_loader : writes a framed, checksummed byte stream into imem and
//               holds the CPU in reset until a frame has loaded cleanly
// Revision 1.0
// ============================================================================
`default_nettype none

module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int unsigned     AW      = 8,
   parameter int unsigned     DW      = 8,
   parameter logic [DW-1:0]   SYNC    = DW'(SYNC_BYTE_DEFAULT),
   parameter int unsigned     TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          wr_en,
   output logic [AW-1:0] wr_ad,
   output logic [DW-1:0] wr_data,
   output logic          cpu_hold,
   output logic          done,
   output logic          err
);

   state_t        state_q,   state_d;
   logic [AW-1:0] addr_q,    addr_d;
   logic [DW-1:0] sum_q,     sum_d;
   logic [DW:0]   cnt_q,     cnt_d;
   logic          wr_en_q,   wr_en_d;
   logic [AW-1:0] wr_ad_q,   wr_ad_d;
   logic [DW-1:0] wr_data_q, wr_data_d;

   logic accept;
   logic active;
   logic timeout;

   assign active   = in_frame(state_q);
   assign in_ready = active || (state_q == ST_SYNC);
   assign accept   = in_valid && in_ready;

   imem_loader_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (accept || !active),
      .en    (active && !accept),
      .tc    (timeout)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      sum_d     = sum_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      wr_ad_d   = wr_ad_q;
      wr_data_d = wr_data_q;

      case (state_q)
         ST_SYNC: begin
            if (accept && (in_data == SYNC)) begin
               state_d = ST_LEN;
            end
         end
         ST_LEN: begin
            if (accept) begin
               // A length byte of zero stands for a full 2^DW-byte frame
               cnt_d   = (in_data == '0) ? {1'b1, {DW{1'b0}}} : {1'b0, in_data};
               addr_d  = '0;
               sum_d   = '0;
               state_d = ST_DATA;
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_DATA: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_ad_d   = addr_q;
               wr_data_d = in_data;
               addr_d    = addr_q + 1'b1;
               sum_d     = sum_q + in_data;
               cnt_d     = cnt_q - 1'b1;
               if (cnt_q == {{DW{1'b0}}, 1'b1}) begin
                  state_d = ST_CSUM;
               end
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_CSUM: begin
            if (accept) begin
               state_d = (in_data == sum_q) ? ST_DONE : ST_ERR;
            end else if (timeout) begin
               state_d = ST_ERR;
            end
         end
         ST_DONE, ST_ERR: begin
            if (start) begin
               state_d = ST_SYNC;
            end
         end
         default: begin
            state_d = ST_SYNC;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_SYNC;
         addr_q    <= '0;
         sum_q     <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_ad_q   <= '0;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         sum_q     <= sum_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         wr_ad_q   <= wr_ad_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en    = wr_en_q;
   assign wr_ad    = wr_ad_q;
   assign wr_data  = wr_data_q;
   assign done     = (state_q == ST_DONE);
   assign err      = (state_q == ST_ERR);
   assign cpu_hold = !done;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// tb_imem_loader : directed self-checking bench for imem_loader
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_imem_loader;

   logic       clk;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       wr_en;
   logic [7:0] wr_ad;
   logic [7:0] wr_data;
   logic       cpu_hold;
   logic       done;
   logic       err;

   int passed = 0;
   int total  = 0;

   imem_loader dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .wr_en    (wr_en),
      .wr_ad    (wr_ad),
      .wr_data  (wr_data),
      .cpu_hold (cpu_hold),
      .done     (done),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Present one byte for exactly one clock edge; returns 1 time unit after the edge
   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic chk_wr(input string tag, input logic [7:0] ad, input logic [7:0] d);
      chk({tag, "_wr_en"}, {31'd0, wr_en}, 32'd1);
      chk({tag, "_wr_ad"}, {24'd0, wr_ad}, {24'd0, ad});
      chk({tag, "_wr_data"}, {24'd0, wr_data}, {24'd0, d});
   endtask

   initial begin
      int bad_ad;
      int wr_seen;

      reset    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      #22;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_wr_en",    {31'd0, wr_en},    32'd0);
      chk("rst_wr_ad",    {24'd0, wr_ad},    32'd0);
      chk("rst_wr_data",  {24'd0, wr_data},  32'd0);
      chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("rst_done",     {31'd0, done},     32'd0);
      chk("rst_err",      {31'd0, err},      32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: three-byte frame, good checksum
      send(8'hA5); send(8'h03);
      send(8'h10); chk_wr("t1_w0", 8'd0, 8'h10);
      send(8'h20); chk_wr("t1_w1", 8'd1, 8'h20);
      send(8'h30); chk_wr("t1_w2", 8'd2, 8'h30);
      send(8'h60);
      chk("t1_wr_en_after", {31'd0, wr_en},    32'd0);
      chk("t1_done",        {31'd0, done},     32'd1);
      chk("t1_cpu_hold",    {31'd0, cpu_hold}, 32'd0);
      chk("t1_in_ready",    {31'd0, in_ready}, 32'd0);
      pulse_start();
      chk("t1_rearm_done",     {31'd0, done},     32'd0);
      chk("t1_rearm_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t1_rearm_in_ready", {31'd0, in_ready}, 32'd1);

      // 2: bad checksum
      send(8'hA5); send(8'h02);
      send(8'h01); chk_wr("t2_w0", 8'd0, 8'h01);
      send(8'h02); chk_wr("t2_w1", 8'd1, 8'h02);
      send(8'hFF);
      chk("t2_err",      {31'd0, err},      32'd1);
      chk("t2_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t2_done",     {31'd0, done},     32'd0);
      pulse_start();
      chk("t2_rearm_err",      {31'd0, err},      32'd0);
      chk("t2_rearm_in_ready", {31'd0, in_ready}, 32'd1);

      // 3: junk before sync is discarded
      send(8'h00); chk("t3_junk0_wr_en", {31'd0, wr_en}, 32'd0);
      send(8'h7E); chk("t3_junk1_wr_en", {31'd0, wr_en}, 32'd0);
      send(8'hA5); send(8'h01);
      send(8'h44); chk_wr("t3_w0", 8'd0, 8'h44);
      send(8'h44);
      chk("t3_done", {31'd0, done}, 32'd1);
      pulse_start();

      // 4: length 0 means 256 bytes, address wraps, sum wraps to 00
      send(8'hA5); send(8'h00);
      bad_ad = 0;
      for (int i = 0; i < 256; i++) begin
         send(8'h01);
         if (!(wr_en === 1'b1 && wr_ad === 8'(i) && wr_data === 8'h01)) bad_ad++;
      end
      chk("t4_bad_writes", bad_ad, 32'd0);
      chk("t4_last_ad", {24'd0, wr_ad}, 32'hFF);
      chk("t4_not_done_before_csum", {31'd0, done}, 32'd0);
      send(8'h00);
      chk("t4_done", {31'd0, done}, 32'd1);
      chk("t4_cpu_hold", {31'd0, cpu_hold}, 32'd0);
      pulse_start();

      // 5: timeout in DATA after one byte
      send(8'hA5); send(8'h04);
      send(8'h11); chk_wr("t5_w0", 8'd0, 8'h11);
      wr_seen = 0;
      for (int i = 0; i < 254; i++) begin
         idle(1);
         if (wr_en !== 1'b0) wr_seen++;
      end
      chk("t5_no_err_at_254", {31'd0, err}, 32'd0);
      idle(1);
      chk("t5_err_at_255", {31'd0, err}, 32'd1);
      chk("t5_cpu_hold",   {31'd0, cpu_hold}, 32'd1);
      idle(3);
      if (wr_en !== 1'b0) wr_seen++;
      chk("t5_no_wr_en", wr_seen, 32'd0);
      pulse_start();

      // Accept arriving in the would-be timeout cycle wins
      send(8'hA5); send(8'h02);
      idle(254);
      chk("tb_err_pre", {31'd0, err}, 32'd0);
      send(8'h05);
      chk("tb_no_err", {31'd0, err}, 32'd0);
      chk_wr("tb_w0", 8'd0, 8'h05);
      send(8'h07); send(8'h0C);
      chk("tb_done", {31'd0, done}, 32'd1);
      pulse_start();

      // 6: asynchronous reset mid-DATA with a write pending
      send(8'hA5); send(8'h03);
      send(8'hAA); chk_wr("t6_w0", 8'd0, 8'hAA);
      in_valid = 1'b1;
      in_data  = 8'hBB;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      chk("t6_wr_en",    {31'd0, wr_en},    32'd0);
      chk("t6_wr_ad",    {24'd0, wr_ad},    32'd0);
      chk("t6_wr_data",  {24'd0, wr_data},  32'd0);
      chk("t6_cpu_hold", {31'd0, cpu_hold}, 32'd1);
      chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
      chk("t6_err",      {31'd0, err},      32'd0);
      @(posedge clk);
      #1;
      chk("t6_wr_en_held", {31'd0, wr_en}, 32'd0);
      in_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      idle(2);
      chk("t6_after_release_wr_en", {31'd0, wr_en}, 32'd0);
      chk("t6_after_release_done",  {31'd0, done},  32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

`default_nettype wire
